// File: rtl/antilog_conv.sv
// antilog_conv: two-stage converter from log domain (k, f) to linear (1.f)*2^k.
// Define ANTILOG_RND_EN to build with round-half-up instead of truncation.
module antilog_conv #(
    parameter int K_W   = 4,
    parameter int F_W   = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_zero,
    input  logic [K_W-1:0]   in_k,
    input  logic [F_W-1:0]   in_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);
    localparam int KMAX = 1 << K_W;
    // m << k needs F_W+1+KMAX-1 bits; one more holds the rounding carry
    localparam int PW = F_W + KMAX;
    localparam int QW = PW - F_W + 1;

    logic             rst_done;
    logic             s1_v;
    logic [F_W:0]     s1_m;
    logic [K_W-1:0]   s1_k;
    logic             s1_z;
    logic             s2_v;
    logic [OUT_W-1:0] s2_d;
    logic             s2_o;

    logic             s2_load;
    logic             in_fire;
    logic [PW:0]      wide_m;
    logic [QW-1:0]    q;
    logic [OUT_W-1:0] low;
    logic             big;
    logic             kbig;
    logic             sat;
    logic [OUT_W-1:0] nxt_d;
    logic             nxt_o;

    assign s2_load  = s1_v && (!s2_v || out_ready);
    assign in_ready = rst_done && (!s1_v || s2_load);
    assign in_fire  = in_valid && in_ready;

    assign wide_m = {{(PW-F_W){1'b0}}, s1_m};

`ifdef ANTILOG_RND_EN
    localparam logic [PW:0] HALF =
        {{(PW-F_W+1){1'b0}}, 1'b1, {(F_W-1){1'b0}}};
    logic [PW:0] rnd;
    // rounding only matters when fraction bits are dropped
    assign rnd = (32'(s1_k) < 32'(F_W)) ? HALF : '0;
    assign q   = QW'(((wide_m << s1_k) + rnd) >> F_W);
`else
    assign q   = QW'((wide_m << s1_k) >> F_W);
`endif

    generate
        if (QW > OUT_W) begin : g_ovf
            assign big = |q[QW-1:OUT_W];
            assign low = q[OUT_W-1:0];
        end else begin : g_fit
            assign big = 1'b0;
            assign low = OUT_W'(q);
        end
    endgenerate

    assign kbig = 32'(s1_k) >= 32'(OUT_W);
    assign sat  = big || kbig;

    // saturate or zero the shifted value before it enters S2
    always_comb begin
        nxt_d = sat ? '1 : low;
        nxt_o = sat;
        if (s1_z) begin
            nxt_d = '0;
            nxt_o = 1'b0;
        end
    end

    // hold off input acceptance until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_done <= 1'b0;
        else     rst_done <= 1'b1;
    end

    // S1: capture mantissa with hidden one, characteristic and zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_m <= '0;
            s1_k <= '0;
            s1_z <= 1'b0;
        end else if (in_fire) begin
            s1_v <= 1'b1;
            s1_m <= {1'b1, in_f};
            s1_k <= in_k;
            s1_z <= in_zero;
        end else if (s2_load) begin
            s1_v <= 1'b0;
        end
    end

    // S2: result register, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2_d <= '0;
            s2_o <= 1'b0;
        end else if (s2_load) begin
            s2_v <= 1'b1;
            s2_d <= nxt_d;
            s2_o <= nxt_o;
        end else if (out_ready) begin
            s2_v <= 1'b0;
        end
    end

    assign out_valid = s2_v;
    assign out_data  = s2_d;
    assign out_ovf   = s2_o;
endmodule

// File: doc/antilog_conv.md
Name: antilog_conv

Overview:
- Pipelined antilogarithm converter: the inverse of the leading-one-detector / log encoder path.
- Takes a log-domain operand (characteristic k = leading-one position, fraction f = bits below the leading one) and reconstructs the linear integer (1.f)·2^k by barrel shift.
- Sits at the output of the log-domain multiplier datapath, after characteristic/fraction addition.
- Uses a valid/ready handshake on both sides.

Parameters:
- K_W, 4, characteristic width; k ranges 0..2^K_W-1.
- F_W, 8, fraction width.
- OUT_W, 16, linear output width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  converter can accept an operand this cycle.
- in_zero  input  1  operand represents 0 (encoder reported no leading one); k and f are ignored.
- in_k  input  K_W  characteristic.
- in_f  input  F_W  fraction.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_W  linear result.
- out_ovf  output  1  result saturated.

Behaviour:
- Reset (async assert, sync release): both stage valids = 0, out_valid = 0, out_data = 0, out_ovf = 0. in_ready = 1 one cycle after reset deasserts.
- Two register stages, so latency is 2 cycles from input transfer to out_valid.
  - S1 captures m = {1'b1, in_f} (F_W+1 bits), k and zero on an input transfer.
  - S2 holds the shifted, truncated result.
- Transfer rule: a transfer occurs when valid && ready on the same rising edge. Data is held stable while out_valid && !out_ready.
- Advance rule:
  - s2_load = s1_v && (!s2_v || out_ready).
  - in_ready = !s1_v || s2_load. This is combinational from out_ready; no skid buffer.
  - Sustained 1 transfer/cycle when out_ready = 1.
- Arithmetic:
  - Compute P = m << k, at width F_W+1+2^K_W-1.
  - out_data = P >> F_W, truncated toward zero.
  - If k >= F_W, no bits are dropped.
- Zero: in_zero = 1 gives out_data = 0 and out_ovf = 0, regardless of k and f.
- Overflow:
  - Applies when k >= OUT_W, or when the shifted value needs more than OUT_W bits.
  - Result: out_data = all ones, out_ovf = 1.
  - Unreachable for the defaults (max 65408); the logic must still exist for K_W=5.
- Simultaneous events:
  - S2 consumed and S1 refilled in the same cycle is legal; no bubble is inserted.
  - Both stages full with out_ready = 0 gives in_ready = 0.
- Reset mid-operation flushes both stages immediately; in-flight operands are discarded, with no partial output.
- out_valid and out_data come directly from S2 flops.

Optional Feature:
- Macro: ANTILOG_RND_EN.
- Defined:
  - Round-half-up: out_data = (P + 2^(F_W-1)) >> F_W, applied only when k < F_W.
  - If the rounding carry exceeds OUT_W, saturate to all ones and set out_ovf = 1.
- Undefined: pure truncation as above; no rounding adder is instantiated.
- Latency and handshake are identical in both builds.

Test Plan:
- k=3, f=0x80, out_ready=1 → out_data=12 (0x000C), out_ovf=0, out_valid exactly 2 cycles after transfer.
- k=0, f=0xFF → out_data=1 (truncate build); with ANTILOG_RND_EN → 2.
- k=15, f=0xFF → 65408 (0xFF80). in_zero=1 with k=9, f=0x55 → 0. K_W=5, k=16 → 0xFFFF, out_ovf=1.
- Back-to-back operands k=1..8 with f=0, and out_ready held 0 for 5 cycles mid-stream:
  - in_ready drops after two operands are held.
  - Outputs 2,4,…,256 arrive in order, none lost or duplicated.
  - out_data is stable while stalled.
- Random out_ready toggling over 1000 random operands → results match the reference model, in order.
- Assert rst while both stages are valid → out_valid=0 and out_data=0 asynchronously. The next operand after release (k=2, f=0x40 → 5) emerges with 2-cycle latency.
